// File: rtl/alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: FSM states,
// default operand width and the slice operation encodings.
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // mode = 0 (arithmetic); SUB is a + ~b + cin, so cin_init=1 gives a - b
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  // mode = 1 (logic); the slice reports cout = 0 for these
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;

endpackage

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds an external 1-bit ALU slice LSB first,
// ripples its carry through a register and assembles the result word.
//
// state | meaning
// IDLE  | waiting for start; y/carry_out hold the last result
// RUN   | WIDTH cycles, one operand bit per cycle through the slice
// DONE  | one cycle, done pulse, y/carry_out just updated
module alu_serial_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opsel,
  input  logic             mode,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry_out,
  output logic             slice_op1,
  output logic             slice_op2,
  output logic             slice_cin,
  output logic [2:0]       slice_opsel,
  output logic             slice_mode,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic [2:0]       opsel_q;
  logic             mode_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_next;

  // Result enters at the MSB and moves right, so after WIDTH shifts
  // bit i holds the slice result of cycle i.
  assign sh_next = {slice_result, sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      y         <= '0;
      carry_out <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sh_q      <= '0;
      opsel_q   <= '0;
      mode_q    <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            opsel_q <= opsel;
            mode_q  <= mode;
            carry_q <= cin_init;
            cnt_q   <= '0;
            sh_q    <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sh_q    <= sh_next;
          carry_q <= slice_cout;
          // terminal-count compare keeps the counter from ever wrapping
          if (cnt_q == LAST_BIT) begin
            y         <= sh_next;
            carry_out <= slice_cout;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign slice_op1   = (state == RUN) & a_q[cnt_q];
  assign slice_op2   = (state == RUN) & b_q[cnt_q];
  assign slice_cin   = (state == RUN) & carry_q;
  assign slice_opsel = opsel_q;
  assign slice_mode  = mode_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq with a behavioural 1-bit slice; results are
// checked against a scoreboard of expected words and done timing.
module tb_alu_serial_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   opsel;
  logic         mode;
  logic         cin_init;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         carry_out;
  logic         slice_op1;
  logic         slice_op2;
  logic         slice_cin;
  logic [2:0]   slice_opsel;
  logic         slice_mode;
  logic         slice_result;
  logic         slice_cout;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .opsel(opsel), .mode(mode), .cin_init(cin_init),
    .busy(busy), .done(done), .y(y), .carry_out(carry_out),
    .slice_op1(slice_op1), .slice_op2(slice_op2), .slice_cin(slice_cin),
    .slice_opsel(slice_opsel), .slice_mode(slice_mode),
    .slice_result(slice_result), .slice_cout(slice_cout)
  );

  // behavioural 1-bit ALU slice
  always_comb begin
    logic op2;
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    op2 = (slice_opsel == OP_SUB) ? ~slice_op2 : slice_op2;
    if (!slice_mode) begin
      {slice_cout, slice_result} = {1'b0, slice_op1} + {1'b0, op2} + {1'b0, slice_cin};
    end else begin
      case (slice_opsel)
        OP_AND:  slice_result = slice_op1 & slice_op2;
        OP_OR:   slice_result = slice_op1 | slice_op2;
        OP_XOR:  slice_result = slice_op1 ^ slice_op2;
        default: slice_result = 1'b0;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   opsel;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] y;
    logic         c;
  } vec_t;

  typedef struct {
    int           neg;
    logic [W-1:0] y;
    logic         c;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (negedge %0d)", name, act, exp, ncyc);
    end
  endtask

  // scoreboard consumer and idle-output monitor
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst_n) begin
      if (!busy || done)
        check("slice_idle_zero", {29'd0, slice_op1, slice_op2, slice_cin}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_latency", ncyc, e.neg);
          check("y", {24'd0, y}, {24'd0, e.y});
          check("carry_out", {31'd0, carry_out}, {31'd0, e.c});
        end
      end
    end
  end

  task automatic push_exp(input int neg, input logic [W-1:0] ey, input logic ec);
    exp_t e;
    e.neg = neg;
    e.y   = ey;
    e.c   = ec;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while ((busy || sb.size() != 0) && k < 100);
    if (busy || sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: timeout busy=%0b pending=%0d", busy, sb.size());
    end
  endtask

  task automatic drive(input vec_t v);
    a        = v.a;
    b        = v.b;
    opsel    = v.opsel;
    mode     = v.mode;
    cin_init = v.cin;
    start    = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    wait_idle();
    drive(v);
    push_exp(ncyc + 9, v.y, v.c);
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   n;
    logic [W-1:0] av;

    vecs[0] = '{OP_ADD, 1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{OP_ADD, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{OP_ADD, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{OP_ADD, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{OP_ADD, 1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{OP_SUB, 1'b0, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
    vecs[6] = '{OP_AND, 1'b1, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    vecs[7] = '{OP_OR,  1'b1, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
    vecs[8] = '{OP_XOR, 1'b1, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    opsel = '0; mode = 1'b0; cin_init = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_carry", {31'd0, carry_out}, 32'd0);
    check("rst_slice", {29'd0, slice_op1, slice_op2, slice_cin}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // carry ripple through the register: 0xFF + 0x01
    wait_idle();
    v = vecs[1];
    av = v.a;
    drive(v);
    push_exp(ncyc + 9, v.y, v.c);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("ripple_cin", {31'd0, slice_cin}, (i == 0) ? 32'd0 : 32'd1);
      check("ripple_op1", {31'd0, slice_op1}, {31'd0, av[i]});
      check("ripple_busy", {31'd0, busy}, 32'd1);
      if (i == 0) begin
        #1 start = 1'b0;
      end
    end

    // start re-pulsed mid-RUN with new operands must be ignored
    run_op(vecs[0]);
    repeat (3) @(negedge clk);
    #1;
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;

    // reset at RUN cycle 4 aborts with no done pulse
    wait_idle();
    drive(vecs[0]);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_y", {24'd0, y}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_carry", {31'd0, carry_out}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    v = '{OP_ADD, 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    run_op(v);

    // start held high: back-to-back ops with one IDLE cycle between
    wait_idle();
    v = '{OP_ADD, 1'b0, 8'h40, 8'h01, 1'b0, 8'h41, 1'b0};
    drive(v);
    n = ncyc;
    push_exp(n + 9,  8'h41, 1'b0);
    push_exp(n + 19, 8'h42, 1'b0);
    push_exp(n + 29, 8'h43, 1'b0);
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      check("b2b_busy", {31'd0, busy}, (i == 10 || i == 20) ? 32'd0 : 32'd1);
      if (i == 10) begin
        #1 b = 8'h02;
      end
      if (i == 20) begin
        #1 b = 8'h03;
      end
    end
    #1 start = 1'b0;

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
